// File: rtl/systolic_mm_nxn.sv
// systolic_mm_nxn: NxN output-stationary systolic matrix multiplier, C = A(NxK) * B(KxN), K chosen per job.
// Define SA_SIGNED_EN for two's-complement operands; the default build treats operands as unsigned.
module systolic_mm_nxn #(
    parameter int unsigned N         = 4,
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned KMAX      = 16,
    parameter int unsigned KW        = $clog2(KMAX + 1),
    parameter int unsigned ACCWIDTH  = 2 * DATAWIDTH + $clog2(KMAX)
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DATAWIDTH-1:0]     a_col,
    input  logic [N*DATAWIDTH-1:0]     b_row,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    output logic [N*N*ACCWIDTH-1:0]    res_data
);
    localparam int unsigned PW  = 2 * DATAWIDTH;
    localparam int unsigned DCW = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t         state;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;

    logic beat_acc_c;
    logic k_ok_c;
    logic job_go_c;

    logic [DATAWIDTH-1:0] a_q    [N];
    logic [DATAWIDTH-1:0] b_q    [N];
    logic [DATAWIDTH-1:0] a_edge [N];
    logic [DATAWIDTH-1:0] b_edge [N];
    logic [DATAWIDTH-1:0] a_op   [N][N];
    logic [DATAWIDTH-1:0] b_op   [N][N];
    logic [DATAWIDTH-1:0] a_r    [N][N-1];
    logic [DATAWIDTH-1:0] b_r    [N-1][N];
    logic [ACCWIDTH-1:0]  acc    [N][N];

    // Product widened to the accumulator; sign or zero extension picked by build option.
    function automatic logic [ACCWIDTH-1:0] mul_ext(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
`ifdef SA_SIGNED_EN
        logic signed [PW-1:0] p;
        p = PW'($signed(a)) * PW'($signed(b));
`else
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b);
`endif
        return ACCWIDTH'(p);
    endfunction

    assign beat_acc_c = in_valid && in_ready;
    assign k_ok_c     = (k_len != '0) && (k_len <= KW'(KMAX));
    assign job_go_c   = (state == S_IDLE) && start && k_ok_c;

    // Job control and registered handshake outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (job_go_c) begin
                        state     <= S_LOAD;
                        k_lat     <= k_len;
                        beat_cnt  <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        res_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat_acc_c) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_lat - KW'(1)) begin
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DCW'(1);
                    if (drain_cnt == DCW'(2 * N - 2)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b1;
                    res_valid <= 1'b1;
                    busy      <= 1'b0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            res_data[(i*N+j)*ACCWIDTH +: ACCWIDTH] <= acc[i][j];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Beat capture: cycles without an accepted beat feed zeros into the array.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= beat_acc_c ? a_col[i*DATAWIDTH +: DATAWIDTH] : '0;
                b_q[i] <= beat_acc_c ? b_row[i*DATAWIDTH +: DATAWIDTH] : '0;
            end
        end
    end

    // Input skew: lane g of A and of B delayed g cycles before entering the array edge.
    for (genvar g = 0; g < N; g++) begin : g_skew
        if (g == 0) begin : g_direct
            assign a_edge[g] = a_q[g];
            assign b_edge[g] = b_q[g];
        end else begin : g_delay
            logic [DATAWIDTH-1:0] a_sk [g];
            logic [DATAWIDTH-1:0] b_sk [g];

            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    for (int d = 0; d < g; d++) begin
                        a_sk[d] <= '0;
                        b_sk[d] <= '0;
                    end
                end else begin
                    a_sk[0] <= a_q[g];
                    b_sk[0] <= b_q[g];
                    for (int d = 1; d < g; d++) begin
                        a_sk[d] <= a_sk[d-1];
                        b_sk[d] <= b_sk[d-1];
                    end
                end
            end

            assign a_edge[g] = a_sk[g-1];
            assign b_edge[g] = b_sk[g-1];
        end
    end

    // Operands seen by each PE: array edge for the first row/column, neighbour register otherwise.
    always_comb begin
        a_op = '{default: '0};
        b_op = '{default: '0};
        for (int i = 0; i < N; i++) begin
            a_op[i][0] = a_edge[i];
            for (int j = 1; j < N; j++) begin
                a_op[i][j] = a_r[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_op[0][j] = b_edge[j];
            for (int i = 1; i < N; i++) begin
                b_op[i][j] = b_r[i-1][j];
            end
        end
    end

    // PE grid: accumulate every cycle, pass a right and b down through one register each.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_r[i][j] <= '0;
                end
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_r[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= job_go_c ? '0 : acc[i][j] + mul_ext(a_op[i][j], b_op[i][j]);
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_r[i][j] <= a_op[i][j];
                end
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_r[i][j] <= b_op[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// tb_systolic_mm_nxn: scoreboard bench for systolic_mm_nxn (N=4, 8-bit operands, KMAX=16).
module tb_systolic_mm_nxn;
    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned KMAX = 16;
    localparam int unsigned KW   = $clog2(KMAX + 1);
    localparam int unsigned AW   = 2 * DW + $clog2(KMAX);
    localparam int unsigned RW   = N * N * AW;

    logic          CLK;
    logic          RSTn;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic [RW-1:0] res_data;

    systolic_mm_nxn #(.N(N), .DATAWIDTH(DW), .KMAX(KMAX)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .busy(busy), .done(done), .res_valid(res_valid), .res_data(res_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] res;
        int            cyc;
        int            id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_first;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    int am [N][KMAX];
    int bm [KMAX][N];
    int cm [N][N];

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(posedge CLK) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (res_data !== mon_e.res) begin
                    errors++;
                    mon_first = -1;
                    for (int x = 0; x < N * N; x++) begin
                        if (mon_first < 0 && res_data[x*AW +: AW] !== mon_e.res[x*AW +: AW]) mon_first = x;
                    end
                    $display("FAIL job%0d res_data: C[%0d][%0d] got %0d, required %0d", mon_e.id,
                             mon_first / N, mon_first % N, res_data[mon_first*AW +: AW],
                             mon_e.res[mon_first*AW +: AW]);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL job%0d done_latency: done at cycle %0d, required %0d", mon_e.id, cyc, mon_e.cyc);
                end
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL job%0d res_valid_at_done: got %b, required 1", mon_e.id, res_valid);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL job%0d busy_at_done: got %b, required 0", mon_e.id, busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic logic [N*DW-1:0] a_beat(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(am[i][k]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] b_beat(input int k);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(bm[k][j]);
        return v;
    endfunction

    function automatic logic [RW-1:0] pack_c();
        logic [RW-1:0] v;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                v[(i*N+j)*AW +: AW] = AW'(cm[i][j]);
        return v;
    endfunction

    // Plain matrix product, wrapped to the accumulator width.
    task automatic model(input int k);
        logic [AW-1:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int kk = 0; kk < k; kk++) s = s + AW'(am[i][kk] * bm[kk][j]);
                cm[i][j] = int'(s);
            end
        end
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, output int acc_cyc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        a_col    = a;
        b_row    = b;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        end
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int id);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 64) begin
            tick();
            g++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL job%0d done_timeout: no done within %0d cycles, required done", id, g);
        end
        tick();
        chk($sformatf("job%0d done_one_cycle", id), 32'(done), 0);
    endtask

    task automatic run_job(input int id, input int k, input bit stall, input logic [RW-1:0] expv);
        int last;
        last = 0;
        start_job(k);
        chk($sformatf("job%0d in_ready_load", id), 32'(in_ready), 1);
        chk($sformatf("job%0d busy_load", id), 32'(busy), 1);
        chk($sformatf("job%0d res_valid_cleared", id), 32'(res_valid), 0);
        for (int kk = 0; kk < k; kk++) begin
            send_beat(a_beat(kk), b_beat(kk), last);
            if (stall && kk != k - 1) begin
                in_valid = 1'b0;
                a_col    = (N*DW)'($urandom);
                b_row    = (N*DW)'($urandom);
                start    = 1'b1;
                k_len    = KW'(3);
                tick();
                start    = 1'b0;
            end
        end
        exp_q.push_back('{res: expv, cyc: last + int'(2 * N), id: id});
        chk($sformatf("job%0d in_ready_drain", id), 32'(in_ready), 0);
        chk($sformatf("job%0d busy_drain", id), 32'(busy), 1);
        if (stall) begin
            start = 1'b1;
            k_len = KW'(2);
            tick();
            start = 1'b0;
        end
        wait_done(id);
    endtask

    initial begin
        int dc0;
        RSTn     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        k_len    = '0;
        a_col    = '0;
        b_row    = '0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data_zero", 32'(res_data == '0), 1);
        RSTn = 1'b1;
        tick();

        // Identity A: C must equal B.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = (i == k) ? 1 : 0;
                bm[k][i] = 4 * k + i + 1;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cm[i][j] = 4 * i + j + 1;
        run_job(1, 4, 1'b0, pack_c());
        repeat (4) tick();
        chk("job1 res_valid_hold", 32'(res_valid), 1);
        chk("job1 res_data_hold", 32'(res_data == pack_c()), 1);

        // K=1 outer product.
        for (int i = 0; i < N; i++) begin
            am[i][0] = i + 1;
            bm[0][i] = i + 5;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cm[i][j] = (i + 1) * (j + 5);
        run_job(2, 1, 1'b0, pack_c());

        // K=KMAX, all operands at maximum; started on the cycle after done.
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = 255;
                bm[k][i] = 255;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cm[i][j] = 1040400;
        run_job(3, 16, 1'b0, pack_c());

        // Same data unstalled and stalled, with ignored starts during LOAD/DRAIN.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = i + 2 * k + 1;
                bm[k][i] = (3 * i + k) % 7 + 1;
            end
        model(4);
        run_job(4, 4, 1'b0, pack_c());
        run_job(5, 4, 1'b1, pack_c());

        // Illegal k_len values are ignored.
        start = 1'b1;
        k_len = KW'(0);
        tick();
        start = 1'b0;
        tick();
        chk("klen0 busy", 32'(busy), 0);
        chk("klen0 in_ready", 32'(in_ready), 0);
        chk("klen0 res_valid_kept", 32'(res_valid), 1);
        start = 1'b1;
        k_len = KW'(17);
        tick();
        start = 1'b0;
        tick();
        chk("klen17 busy", 32'(busy), 0);
        chk("klen17 res_valid_kept", 32'(res_valid), 1);

        // Reset in the middle of LOAD, then a full job.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = (5 * i + k * k) % 256;
                bm[k][i] = 200 - 13 * i - 7 * k;
            end
        model(4);
        begin
            int lc;
            start_job(4);
            send_beat(a_beat(0), b_beat(0), lc);
            send_beat(a_beat(1), b_beat(1), lc);
        end
        RSTn = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst res_valid", 32'(res_valid), 0);
        chk("midrst res_data_zero", 32'(res_data == '0), 1);
        tick();
        RSTn = 1'b1;
        tick();
        dc0 = done_cnt;
        run_job(6, 4, 1'b0, pack_c());
        repeat (3) tick();
        chk("job6 done_pulses", 32'(done_cnt - dc0), 1);

        // All A = 8'hFF, all B = 8'hFD.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = 255;
                bm[k][i] = 253;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
`ifdef SA_SIGNED_EN
                cm[i][j] = 6;
`else
                cm[i][j] = 129030;
`endif
            end
        run_job(7, 2, 1'b0, pack_c());

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
